// File: rtl/hfosc_power_sequencer.sv
// HFOSC power sequencer: powers up, settles, runs, drains
// and powers down the iCE40 high-frequency oscillator.
module hfosc_power_sequencer #(
  parameter int          SETTLE_CYCLES = 16,
  parameter int          DRAIN_CYCLES  = 4,
  parameter int          IDLE_TIMEOUT  = 0,
  parameter logic [31:0] TRIGGER_ADDR  = 32'h1000,
  parameter int          CNT_W         = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] rdsp,
  input  logic        activity,
  input  logic        sleep_req,
  input  logic        wake_req,
  output logic        clkhf_powerup,
  output logic        clkhf_enable,
  output logic        clk_ready,
  output logic [1:0]  state_o
);

  localparam logic [1:0] S_OFF    = 2'b00;
  localparam logic [1:0] S_SETTLE = 2'b01;
  localparam logic [1:0] S_RUN    = 2'b10;
  localparam logic [1:0] S_DRAIN  = 2'b11;

  localparam int IDLE_M1 =
    (IDLE_TIMEOUT == 0) ? 0 : IDLE_TIMEOUT - 1;

  localparam logic [CNT_W-1:0] SETTLE_LAST =
    CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST =
    CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST =
    CNT_W'(IDLE_M1);
  localparam logic IDLE_EN = (IDLE_TIMEOUT != 0);

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             match_q;
  logic             match;
  logic             trig_pulse;
  logic             idle_hit;
  logic             sleep_cond;
  logic             pu_d;
  logic             en_d;
  logic             pu_q;
  logic             en_q;
  logic             rdy_q;

  assign match      = (rdsp == TRIGGER_ADDR);
  assign trig_pulse = match && !match_q;
  assign idle_hit   = IDLE_EN && (cnt_q == IDLE_LAST)
                      && !activity;
  assign sleep_cond = sleep_req || trig_pulse || idle_hit;

  // State, counter, trigger history and registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_SETTLE;
      cnt_q   <= '0;
      match_q <= 1'b0;
      pu_q    <= 1'b1;
      en_q    <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      match_q <= match;
      pu_q    <= pu_d;
      en_q    <= en_d;
      rdy_q   <= en_d;
    end
  end

  // Next state and shared settle/drain/idle counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_OFF: begin
        if (wake_req) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (activity) begin
          cnt_d = '0;
        end else if (IDLE_EN && cnt_q != IDLE_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (!wake_req && sleep_cond) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end
      end
      S_DRAIN: begin
        if (wake_req) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end else if (cnt_q == DRAIN_LAST) begin
          state_d = S_OFF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_SETTLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the upcoming state
  always_comb begin
    pu_d = 1'b0;
    en_d = 1'b0;
    unique case (1'b1)
      (state_d == S_RUN): begin
        pu_d = 1'b1;
        en_d = 1'b1;
      end
      (state_d == S_SETTLE),
      (state_d == S_DRAIN): pu_d = 1'b1;
      default: pu_d = 1'b0;
    endcase
  end

  assign clkhf_powerup = pu_q;
  assign clkhf_enable  = en_q;
  assign clk_ready     = rdy_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_hfosc_power_sequencer.sv
// Self-checking bench for hfosc_power_sequencer against
// a phase-duration reference model.
module tb_hfosc_power_sequencer;

  localparam int          SETTLE = 16;
  localparam int          DRAIN  = 4;
  localparam int          IDLE   = 8;
  localparam logic [31:0] TRIG   = 32'h1000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] rdsp = 32'h0;
  logic        activity = 1'b1;
  logic        sleep_req = 1'b0;
  logic        wake_req = 1'b0;
  logic        clkhf_powerup;
  logic        clkhf_enable;
  logic        clk_ready;
  logic [1:0]  state_o;

  int n_vec = 0;
  int n_bad = 0;

  int m_st = 1;
  int m_el = 0;
  int m_idle = 0;
  bit m_prev = 1'b0;

  hfosc_power_sequencer #(
    .SETTLE_CYCLES(SETTLE),
    .DRAIN_CYCLES (DRAIN),
    .IDLE_TIMEOUT (IDLE),
    .TRIGGER_ADDR (TRIG),
    .CNT_W        (16)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rdsp         (rdsp),
    .activity     (activity),
    .sleep_req    (sleep_req),
    .wake_req     (wake_req),
    .clkhf_powerup(clkhf_powerup),
    .clkhf_enable (clkhf_enable),
    .clk_ready    (clk_ready),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  // Model: phase + cycles spent in it, idle run length.
  task automatic model_update();
    bit hit;
    if (!reset_n) begin
      m_st = 1; m_el = 0; m_idle = 0; m_prev = 1'b0;
      return;
    end
    hit = (rdsp == TRIG) && !m_prev;
    m_prev = (rdsp == TRIG);
    case (m_st)
      0: if (wake_req) begin m_st = 1; m_el = 0; end
      1: begin
        m_el++;
        if (m_el == SETTLE) begin m_st = 2; m_idle = 0; end
      end
      2: begin
        m_idle = activity ? 0 : m_idle + 1;
        if (!wake_req && (sleep_req || hit ||
            (IDLE != 0 && m_idle >= IDLE))) begin
          m_st = 3; m_el = 0;
        end
      end
      default: begin
        m_el++;
        if (wake_req) begin m_st = 1; m_el = 0; end
        else if (m_el == DRAIN) m_st = 0;
      end
    endcase
  endtask

  function automatic logic [4:0] model_out();
    logic [1:0] s;
    s = m_st[1:0];
    return {s, (m_st != 0), (m_st == 2), (m_st == 2)};
  endfunction

  function automatic logic [4:0] got();
    return {state_o, clkhf_powerup, clkhf_enable, clk_ready};
  endfunction

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    logic [4:0] e;
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_vec++;
      if (got() !== 5'b01100) begin
        n_bad++;
        $display("FAIL reset_hold got=%b exp=%b", got(), 5'b01100);
      end
    end
    reset_n = 1'b1;
    for (int i = 1; i <= SETTLE; i++) begin
      step();
      e = (i < SETTLE) ? 5'b01100 : 5'b10111;
      n_vec++;
      if (got() !== e) begin
        n_bad++;
        $display("FAIL reset_settle i=%0d got=%b exp=%b", i, got(), e);
      end
    end
  endtask

  task automatic test_sleep();
    logic [4:0] e;
    activity = 1'b1;
    sleep_req = 1'b1;
    step();
    sleep_req = 1'b0;
    n_vec++;
    if (got() !== 5'b11100) begin
      n_bad++;
      $display("FAIL sleep_enter got=%b exp=%b", got(), 5'b11100);
    end
    for (int i = 1; i <= DRAIN; i++) begin
      step();
      e = (i < DRAIN) ? 5'b11100 : 5'b00000;
      n_vec++;
      if (got() !== e) begin
        n_bad++;
        $display("FAIL sleep_drain i=%0d got=%b exp=%b", i, got(), e);
      end
    end
    wake_req = 1'b1;
    step();
    wake_req = 1'b0;
    for (int i = 1; i <= SETTLE; i++) begin
      step();
      e = (i < SETTLE) ? 5'b01100 : 5'b10111;
      n_vec++;
      if (got() !== e) begin
        n_bad++;
        $display("FAIL wake_off i=%0d got=%b exp=%b", i, got(), e);
      end
    end
  endtask

  task automatic test_trigger();
    int entries;
    logic [1:0] prev;
    entries = 0;
    rdsp = TRIG;
    for (int i = 0; i < 50; i++) begin
      prev = state_o;
      step();
      if (prev == 2'b10 && state_o == 2'b11) entries++;
    end
    n_vec++;
    if (entries != 1 || state_o !== 2'b00) begin
      n_bad++;
      $display("FAIL trig_hold entries=%0d st=%b exp=1/00", entries, state_o);
    end
    wake_req = 1'b1;
    step();
    wake_req = 1'b0;
    repeat (SETTLE + 20) step();
    n_vec++;
    if (state_o !== 2'b10) begin
      n_bad++;
      $display("FAIL trig_no_resleep got=%b exp=10", state_o);
    end
    rdsp = TRIG - 32'd4;
    step();
    rdsp = TRIG;
    step();
    n_vec++;
    if (state_o !== 2'b11 || clkhf_enable !== 1'b0) begin
      n_bad++;
      $display("FAIL trig_rearm got=%b exp=11", state_o);
    end
    rdsp = 32'h0;
  endtask

  task automatic test_idle();
    logic [1:0] e;
    wake_req = 1'b1;
    step();
    wake_req = 1'b0;
    repeat (SETTLE) step();
    activity = 1'b0;
    for (int i = 1; i <= IDLE; i++) begin
      step();
      e = (i < IDLE) ? 2'b10 : 2'b11;
      n_vec++;
      if (state_o !== e) begin
        n_bad++;
        $display("FAIL idle_timeout i=%0d got=%b exp=%b", i, state_o, e);
      end
    end
    wake_req = 1'b1;
    step();
    wake_req = 1'b0;
    repeat (SETTLE) step();
    repeat (4) step();
    activity = 1'b1;
    step();
    activity = 1'b0;
    for (int i = 1; i <= IDLE; i++) begin
      step();
      e = (i < IDLE) ? 2'b10 : 2'b11;
      n_vec++;
      if (state_o !== e) begin
        n_bad++;
        $display("FAIL idle_restart i=%0d got=%b exp=%b", i, state_o, e);
      end
    end
  endtask

  task automatic test_wake_drain();
    logic [4:0] e;
    repeat (2) step();
    wake_req = 1'b1;
    step();
    wake_req = 1'b0;
    n_vec++;
    if (got() !== 5'b01100) begin
      n_bad++;
      $display("FAIL wake_drain got=%b exp=%b", got(), 5'b01100);
    end
    activity = 1'b1;
    for (int i = 1; i <= SETTLE; i++) begin
      step();
      e = (i < SETTLE) ? 5'b01100 : 5'b10111;
      n_vec++;
      if (got() !== e) begin
        n_bad++;
        $display("FAIL wake_drain_settle i=%0d got=%b exp=%b", i, got(), e);
      end
    end
    sleep_req = 1'b1;
    wake_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_vec++;
      if (got() !== 5'b10111) begin
        n_bad++;
        $display("FAIL wake_beats_sleep got=%b exp=%b", got(), 5'b10111);
      end
    end
    sleep_req = 1'b0;
    wake_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [4:0] e;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        sleep_req = 1'b1;
        step();
        sleep_req = 1'b0;
      end
      step();
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      n_vec++;
      if (got() !== 5'b01100) begin
        n_bad++;
        $display("FAIL reset_mid k=%0d got=%b exp=%b", k, got(), 5'b01100);
      end
      for (int i = 1; i <= SETTLE; i++) begin
        step();
        e = (i < SETTLE) ? 5'b01100 : 5'b10111;
        n_vec++;
        if (got() !== e) begin
          n_bad++;
          $display("FAIL reset_mid_settle k=%0d i=%0d got=%b exp=%b",
                   k, i, got(), e);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      reset_n   = ($urandom_range(0, 199) != 0);
      activity  = ($urandom_range(0, 3) == 0);
      sleep_req = ($urandom_range(0, 24) == 0);
      wake_req  = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0, 1:    rdsp = TRIG;
          2:       rdsp = TRIG - 32'd4;
          default: rdsp = $urandom;
        endcase
      end
      step();
      n_vec++;
      if (got() !== model_out()) begin
        n_bad++;
        $display("FAIL random i=%0d got=%b exp=%b", i, got(), model_out());
      end
    end
    reset_n = 1'b1;
    sleep_req = 1'b0;
    wake_req = 1'b0;
  endtask

  initial begin
    #2;
    test_reset();
    test_sleep();
    test_trigger();
    test_idle();
    test_wake_drain();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
